// File: rtl/pipe5_types_pkg.sv
// Shared types for the 5-stage pipeline: fetch FSM states, the NOP encoding and the F/D latch
// layout consumed by decode.
package pipe5_types_pkg;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    DISCARD
  } fetch_state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        fault;
    logic        mal;
  } fd_latch_t;

  function automatic fd_latch_t fd_bubble();
    fd_latch_t b;
    b       = '0;
    b.instr = NOP_INSN;
    return b;
  endfunction

endpackage

// File: rtl/pipe5_fetch_stage_if.sv
// Instruction-memory generic bus: fetch stage is master, memory is slave.
interface pipe5_fetch_stage_if;
  logic        iren;
  logic [31:0] iaddr;
  logic        ibusy;
  logic [31:0] irdata;
  logic        ierror;

  modport master (
    output iren,
    output iaddr,
    input  ibusy,
    input  irdata,
    input  ierror
  );

  modport slave (
    input  iren,
    input  iaddr,
    output ibusy,
    output irdata,
    output ierror
  );
endinterface

// File: rtl/pipe5_fetch_stage.sv
// Fetch stage: owns the PC, drives the imem bus and loads the F/D latch. A one-entry hold buffer
// keeps a fetch that completes during a stall so it is never refetched.
module pipe5_fetch_stage
  import pipe5_types_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0200
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       pc_en,
  input  logic                       fd_stall,
  input  logic                       fd_flush,
  input  logic                       npc_sel,
  input  logic [31:0]                branch_target,
  input  logic                       insert_priv_pc,
  input  logic [31:0]                priv_pc,
  pipe5_fetch_stage_if.master        imem,
  output logic                       f_busy,
  output logic                       fd_valid,
  output logic [31:0]                fd_instr,
  output logic [31:0]                fd_pc,
  output logic [31:0]                fd_pc4,
  output logic                       fd_fault_insn,
  output logic                       fd_mal_insn
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pend_pc_q, pend_pc_d;
  fd_latch_t    buf_q, buf_d;
  logic         buf_valid_q, buf_valid_d;
  fd_latch_t    fd_q, fd_d;

  logic         misaligned;
  logic         bus_done;
  logic         fetch_done;
  logic         redirect;
  logic         adv;
  logic [31:0]  target;
  logic [31:0]  pc_plus4;
  fd_latch_t    fetched;
  logic         load;
  fd_latch_t    load_val;

  assign misaligned = |pc_q[1:0];
  assign redirect   = insert_priv_pc | npc_sel;
  assign target     = insert_priv_pc ? priv_pc : branch_target;
  assign adv        = pc_en & ~fd_stall & ~fd_flush;
  assign pc_plus4   = pc_q + 32'd4;

  // A misaligned PC never reaches the bus; it completes at once as a NOP flagged misaligned.
  assign imem.iren  = nRST & (((state_q == FETCH) & ~misaligned) | (state_q == DISCARD));
  assign imem.iaddr = pc_q;
  assign bus_done   = imem.iren & ~imem.ibusy;
  assign fetch_done = (state_q == FETCH) & (misaligned | bus_done);
  assign f_busy     = imem.iren & imem.ibusy;

  always_comb begin
    fetched       = '0;
    fetched.valid = 1'b1;
    fetched.instr = misaligned ? NOP_INSN : imem.irdata;
    fetched.pc    = pc_q;
    fetched.pc4   = pc_plus4;
    fetched.fault = misaligned ? 1'b0 : imem.ierror;
    fetched.mal   = misaligned;
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_pc_d   = pend_pc_q;
    buf_d       = buf_q;
    buf_valid_d = buf_valid_q;
    load        = 1'b0;
    load_val    = fd_bubble();

    unique case (state_q)
      FETCH: begin
        if (fetch_done) begin
          if (redirect) begin
            pc_d = target;
          end else if (adv) begin
            load     = 1'b1;
            load_val = fetched;
            pc_d     = pc_plus4;
          end else begin
            // Completion while decode cannot accept: park it rather than drop it.
            buf_d       = fetched;
            buf_valid_d = 1'b1;
            state_d     = HOLD;
          end
        end else if (redirect) begin
          pend_pc_d = target;
          state_d   = DISCARD;
        end
      end

      HOLD: begin
        if (redirect) begin
          buf_valid_d = 1'b0;
          pc_d        = target;
          state_d     = FETCH;
        end else if (adv && buf_valid_q) begin
          load        = 1'b1;
          load_val    = buf_q;
          pc_d        = pc_plus4;
          buf_valid_d = 1'b0;
          state_d     = FETCH;
        end
      end

      DISCARD: begin
        // The stale request must run to completion with a stable address before retargeting.
        if (bus_done) begin
          pc_d    = redirect ? target : pend_pc_q;
          state_d = FETCH;
        end else if (redirect) begin
          pend_pc_d = target;
        end
      end

      default: begin
        state_d = FETCH;
      end
    endcase

    if (fd_flush) begin
      fd_d = fd_bubble();
    end else if (fd_stall) begin
      fd_d = fd_q;
    end else if (load) begin
      fd_d = load_val;
    end else begin
      fd_d = fd_bubble();
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      pend_pc_q   <= RESET_PC;
      buf_q       <= fd_bubble();
      buf_valid_q <= 1'b0;
      fd_q        <= fd_bubble();
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_pc_q   <= pend_pc_d;
      buf_q       <= buf_d;
      buf_valid_q <= buf_valid_d;
      fd_q        <= fd_d;
    end
  end

  assign fd_valid      = fd_q.valid;
  assign fd_instr      = fd_q.instr;
  assign fd_pc         = fd_q.pc;
  assign fd_pc4        = fd_q.pc4;
  assign fd_fault_insn = fd_q.fault;
  assign fd_mal_insn   = fd_q.mal;

endmodule

// File: tb/tb_pipe5_fetch_stage.sv
// Bench for pipe5_fetch_stage: directed plan items, then randomized hazard/bus stimulus checked
// by a scoreboard against an in-order program-stream model.
module tb_pipe5_fetch_stage;
  import pipe5_types_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0200;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        pc_en, fd_stall, fd_flush, npc_sel, insert_priv_pc;
  logic [31:0] branch_target, priv_pc;
  logic        f_busy, fd_valid, fd_fault_insn, fd_mal_insn;
  logic [31:0] fd_instr, fd_pc, fd_pc4;

  int checks    = 0;
  int failures  = 0;
  int delivered = 0;

  pipe5_fetch_stage_if bus();

  pipe5_fetch_stage #(.RESET_PC(RST_PC)) dut (
    .CLK            (CLK),
    .nRST           (nRST),
    .pc_en          (pc_en),
    .fd_stall       (fd_stall),
    .fd_flush       (fd_flush),
    .npc_sel        (npc_sel),
    .branch_target  (branch_target),
    .insert_priv_pc (insert_priv_pc),
    .priv_pc        (priv_pc),
    .imem           (bus),
    .f_busy         (f_busy),
    .fd_valid       (fd_valid),
    .fd_instr       (fd_instr),
    .fd_pc          (fd_pc),
    .fd_pc4         (fd_pc4),
    .fd_fault_insn  (fd_fault_insn),
    .fd_mal_insn    (fd_mal_insn)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0200) return 32'h0050_0093;
    if (a == 32'h0000_0204) return 32'h00A0_0113;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic mem_err(input logic [31:0] a);
    return a[5:2] == 4'hB;
  endfunction

  assign bus.irdata = mem_word(bus.iaddr);
  assign bus.ierror = mem_err(bus.iaddr);

  // Reference: decode must see the program stream in order from the last redirect target.
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        fault;
    logic        mal;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_pc;

  function automatic exp_t expect_at(input logic [31:0] a);
    exp_t e;
    e.pc    = a;
    e.pc4   = a + 32'd4;
    e.mal   = (a % 4) != 0;
    e.instr = e.mal ? 32'h0000_0013 : mem_word(a);
    e.fault = e.mal ? 1'b0 : mem_err(a);
    return e;
  endfunction

  task automatic model_fill();
    while (exp_q.size() < 4) begin
      exp_q.push_back(expect_at(ref_pc));
      ref_pc = ref_pc + 32'd4;
    end
  endtask

  task automatic model_restart(input logic [31:0] a);
    exp_q.delete();
    ref_pc = a;
    model_fill();
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%b want=%b t=%0t", name, got, want, $time);
    end
  endtask

  initial begin : monitor
    logic        held_edge;
    logic        prev_busy;
    logic [31:0] prev_addr;
    exp_t        e;
    held_edge = 1'b1;
    prev_busy = 1'b0;
    prev_addr = '0;
    model_restart(RST_PC);
    forever begin
      @(posedge CLK);
      held_edge = fd_stall && !fd_flush;
      if (!nRST) model_restart(RST_PC);
      else if (insert_priv_pc) model_restart(priv_pc);
      else if (npc_sel) model_restart(branch_target);
      @(negedge CLK);
      if (fd_valid && !held_edge) begin
        e = exp_q.pop_front();
        checks++;
        if ({fd_instr, fd_pc, fd_pc4, fd_fault_insn, fd_mal_insn} !==
            {e.instr, e.pc, e.pc4, e.fault, e.mal}) begin
          failures++;
          $display("FAIL fd_entry got pc=%h instr=%h pc4=%h fault=%b mal=%b want pc=%h instr=%h pc4=%h fault=%b mal=%b t=%0t",
                   fd_pc, fd_instr, fd_pc4, fd_fault_insn, fd_mal_insn,
                   e.pc, e.instr, e.pc4, e.fault, e.mal, $time);
        end
        delivered++;
        model_fill();
      end
      if (nRST) begin
        chk1("f_busy", f_busy, bus.iren & bus.ibusy);
        if (bus.iren) chk("iaddr_align", {30'b0, bus.iaddr[1:0]}, 32'd0);
        if (prev_busy) begin
          chk1("busy_iren_held", bus.iren, 1'b1);
          chk("busy_iaddr_stable", bus.iaddr, prev_addr);
        end
      end
      prev_busy = nRST && bus.iren && bus.ibusy;
      prev_addr = bus.iaddr;
    end
  end

  task automatic drive();
    @(posedge CLK);
    #1;
  endtask

  task automatic smp();
    @(negedge CLK);
  endtask

  task automatic clear_redirect();
    npc_sel        = 1'b0;
    insert_priv_pc = 1'b0;
    fd_flush       = 1'b0;
  endtask

  function automatic logic [31:0] pick_target();
    int unsigned r;
    r = $urandom_range(0, 15);
    if (r == 0) return 32'hFFFF_FFF4;
    if (r == 1) return 32'h0000_0402 + ($urandom_range(0, 63) << 2);
    return 32'h0000_1000 + ($urandom_range(0, 1023) << 2);
  endfunction

  initial begin : driver
    nRST           = 1'b0;
    pc_en          = 1'b1;
    fd_stall       = 1'b0;
    fd_flush       = 1'b0;
    npc_sel        = 1'b0;
    insert_priv_pc = 1'b0;
    branch_target  = '0;
    priv_pc        = '0;
    bus.ibusy      = 1'b0;

    repeat (3) @(posedge CLK);
    smp();
    chk1("rst_iren", bus.iren, 1'b0);
    chk1("rst_fd_valid", fd_valid, 1'b0);
    chk("rst_fd_instr", fd_instr, NOP_INSN);
    chk("rst_fd_pc", fd_pc, 32'd0);
    chk("rst_fd_pc4", fd_pc4, 32'd0);
    chk1("rst_fault", fd_fault_insn, 1'b0);
    chk1("rst_mal", fd_mal_insn, 1'b0);

    drive(); nRST = 1'b1;
    smp();
    chk1("first_iren", bus.iren, 1'b1);
    chk("first_iaddr", bus.iaddr, 32'h200);
    smp();
    chk1("lat_fd_valid", fd_valid, 1'b1);
    chk("lat_fd_pc", fd_pc, 32'h200);
    chk("lat_fd_instr", fd_instr, 32'h0050_0093);

    // 0x208 waits three cycles on the bus
    drive(); bus.ibusy = 1'b1;
    smp();
    chk("seq_fd_pc", fd_pc, 32'h204);
    chk("busy_iaddr", bus.iaddr, 32'h208);
    chk1("busy_f_busy0", f_busy, 1'b1);
    smp();
    chk1("busy_fd_valid", fd_valid, 1'b0);
    chk1("busy_f_busy1", f_busy, 1'b1);
    smp();
    chk1("busy_f_busy2", f_busy, 1'b1);
    drive(); bus.ibusy = 1'b0;
    smp();
    chk1("busy_fd_valid2", fd_valid, 1'b0);

    // 0x20C completes under stall and must be parked, not refetched
    drive(); fd_stall = 1'b1; pc_en = 1'b0;
    smp();
    chk("after_busy_pc", fd_pc, 32'h208);
    chk("after_busy_instr", fd_instr, mem_word(32'h208));
    chk("hold_fetch_addr", bus.iaddr, 32'h20C);
    smp();
    chk1("hold_iren0", bus.iren, 1'b0);
    smp();
    chk1("hold_iren1", bus.iren, 1'b0);
    drive(); fd_stall = 1'b0; pc_en = 1'b1;
    smp();
    chk1("hold_iren2", bus.iren, 1'b0);

    // branch to 0x400 while 0x210 is busy
    drive();
    bus.ibusy = 1'b1; npc_sel = 1'b1; branch_target = 32'h400; fd_flush = 1'b1;
    smp();
    chk1("hold_release_valid", fd_valid, 1'b1);
    chk("hold_release_pc", fd_pc, 32'h20C);
    chk("disc_busy_addr", bus.iaddr, 32'h210);
    drive(); clear_redirect();
    smp();
    chk1("disc_iren", bus.iren, 1'b1);
    chk("disc_iaddr0", bus.iaddr, 32'h210);
    drive(); bus.ibusy = 1'b0;
    smp();
    chk("disc_iaddr1", bus.iaddr, 32'h210);
    smp();
    chk("disc_target", bus.iaddr, 32'h400);
    chk1("disc_no_data", fd_valid, 1'b0);
    smp();
    chk("branch_fd_pc", fd_pc, 32'h400);

    // privilege redirect beats a simultaneous branch
    drive();
    insert_priv_pc = 1'b1; priv_pc = 32'h800;
    npc_sel = 1'b1; branch_target = 32'h400; fd_flush = 1'b1;
    drive(); clear_redirect();
    smp();
    chk("priv_priority", bus.iaddr, 32'h800);

    // misaligned redirect
    drive(); npc_sel = 1'b1; branch_target = 32'h402; fd_flush = 1'b1;
    drive(); clear_redirect();
    smp();
    chk1("mal_no_iren", bus.iren, 1'b0);
    smp();
    chk1("mal_valid", fd_valid, 1'b1);
    chk1("mal_flag", fd_mal_insn, 1'b1);
    chk("mal_instr", fd_instr, NOP_INSN);
    chk("mal_pc", fd_pc, 32'h402);

    // bus error
    drive(); npc_sel = 1'b1; branch_target = 32'h22C; fd_flush = 1'b1;
    drive(); clear_redirect();
    smp();
    chk("err_iaddr", bus.iaddr, 32'h22C);
    smp();
    chk("err_pc", fd_pc, 32'h22C);
    chk1("err_fault", fd_fault_insn, 1'b1);

    // reset in the middle of a busy request
    drive(); bus.ibusy = 1'b1;
    smp();
    chk1("midrst_busy", f_busy, 1'b1);
    drive(); nRST = 1'b0;
    smp();
    chk1("midrst_iren", bus.iren, 1'b0);
    drive(); nRST = 1'b1; bus.ibusy = 1'b0;
    smp();
    chk1("midrst_fd_valid", fd_valid, 1'b0);
    chk("midrst_pc", bus.iaddr, 32'h200);
    smp();
    chk("midrst_fd_pc", fd_pc, 32'h200);

    delivered = 0;
    for (int c = 0; c < 3000; c++) begin
      drive();
      bus.ibusy      = ($urandom_range(0, 99) < 30);
      pc_en          = ($urandom_range(0, 99) < 85);
      fd_stall       = ($urandom_range(0, 99) < 20);
      fd_flush       = ($urandom_range(0, 99) < 8);
      npc_sel        = ($urandom_range(0, 99) < 5);
      insert_priv_pc = ($urandom_range(0, 99) < 3);
      branch_target  = pick_target();
      priv_pc        = pick_target();
      if (npc_sel || insert_priv_pc) fd_flush = 1'b1;
      nRST           = ($urandom_range(0, 999) != 0);
    end
    drive();
    nRST = 1'b1; bus.ibusy = 1'b0; pc_en = 1'b1; fd_stall = 1'b0;
    clear_redirect();
    repeat (5) smp();
    chk1("progress", delivered >= 300, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe5_fetch_stage.md
Name: pipe5_fetch_stage

Overview:
- Fetch stage of the 5-stage pipeline: owns the PC, drives the instruction-memory generic bus, and loads the F/D pipeline latch consumed by decode.
- Obeys the hazard/forwarding unit's pc_en, fd_stall and fd_flush.
- Reports f_busy back to the hazard unit.
- Applies redirects from the privilege unit and from resolved branches/jumps in M.
- Includes a one-entry hold buffer so a fetch that completes during a stall is never lost or refetched.

Parameters:
- RESET_PC, 32'h0000_0200, PC loaded on reset.

Ports:
- CLK  in  1  clock, all state updates on rising edge.
- nRST  in  1  reset, synchronous, active-low.
- pc_en  in  1  hazard unit: PC may advance.
- fd_stall  in  1  hazard unit: hold F/D latch.
- fd_flush  in  1  hazard unit: load bubble into F/D latch.
- npc_sel  in  1  branch/jump redirect from M.
- branch_target  in  32  redirect PC from M.
- insert_priv_pc  in  1  privilege redirect (trap/xRET).
- priv_pc  in  32  privilege redirect PC.
- iren  out  1  imem read request.
- iaddr  out  32  imem address.
- ibusy  in  1  imem busy; transfer completes in a cycle with iren=1 and ibusy=0.
- irdata  in  32  imem read data, valid on completion.
- ierror  in  1  bus error, valid on completion.
- f_busy  out  1  to hazard unit: request outstanding (iren & ibusy).
- fd_valid  out  1  F/D latch holds a real instruction.
- fd_instr  out  32  F/D instruction.
- fd_pc  out  32  F/D PC.
- fd_pc4  out  32  fd_pc+4.
- fd_fault_insn  out  1  access fault on this fetch.
- fd_mal_insn  out  1  misaligned PC on this fetch.

Behaviour:
- Reset (nRST=0 at edge):
  - pc=RESET_PC, state=FETCH, buf_valid=0.
  - fd_valid=0, fd_instr=NOP (32'h0000_0013), fd_pc=fd_pc4=0, fault/mal flags=0.
  - iren=0 while nRST=0.
  - Reset mid-request abandons the request; no data is captured.
- Redirect:
  - redirect = insert_priv_pc | npc_sel.
  - Target = priv_pc if insert_priv_pc, else branch_target (privilege has priority).
- Misaligned PC:
  - pc[1:0]!=0 means no bus request is issued; iren=0.
  - Treated as an instant completion with data=NOP, mal=1.
- Advance condition: adv = pc_en & ~fd_stall & ~fd_flush.
- FSM state FETCH:
  - Drives iren=1, iaddr=pc.
  - ibusy=1 and redirect: pend_pc<=target, go to DISCARD.
  - Completion with redirect: data dropped, pc<=target, stay in FETCH.
  - Completion with adv: F/D<={1, irdata, pc, pc+4, ierror, 0}, pc<=pc+4.
  - Completion otherwise: buf<=data/flags, buf_valid=1, go to HOLD.
- FSM state HOLD:
  - iren=0.
  - redirect: buf_valid<=0, pc<=target, go to FETCH.
  - adv: F/D<=buf, pc<=pc+4, buf_valid<=0, go to FETCH.
- FSM state DISCARD:
  - Drives iren=1 with iaddr=pc held stable; the bus protocol requires the address to be stable while ibusy=1.
  - A new redirect overwrites pend_pc.
  - On completion: data dropped, pc<=pend_pc, go to FETCH.
- F/D latch priority: fd_flush loads a bubble (valid=0, instr=NOP, flags=0) > fd_stall holds > load from the FSM action above > otherwise bubble.
- Latency: zero-wait imem gives 1 instruction/cycle; fetch-to-fd_valid is 1 cycle.
- f_busy=1 in FETCH/DISCARD while ibusy=1; otherwise 0.
- Simultaneous flush and completion without redirect: data goes to buf (HOLD), not dropped.
- PC arithmetic is 32-bit and wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0).

Decomposition:
- pipe5_types_pkg gains:
  - fetch_state_t enum {FETCH, HOLD, DISCARD}.
  - NOP_INSN constant.
  - fd_latch_t packed struct {valid, instr, pc, pc4, fault, mal}, shared with decode.
- No sub-module: the FSM, hold buffer and latch are one always_ff plus one always_comb.

Test Plan:
- Reset, zero-wait imem, mem[0x200]=0x00500093, mem[0x204]=0x00A00113 -> cycle 1 fd_pc=0x200, fd_instr=0x00500093; next cycle fd_pc=0x204.
- ibusy=1 for 3 cycles at 0x208 -> f_busy=1 for 3 cycles, fd_valid=0 (flushed); then fd_instr=mem[0x208], PC=0x20C.
- fd_stall=1, pc_en=0 when 0x20C completes -> HOLD, iren=0; stall released -> fd_pc=0x20C with no second bus read.
- npc_sel=1, branch_target=0x400 while 0x210 busy -> DISCARD keeps iaddr=0x210; after completion iaddr=0x400 and mem[0x210] never reaches fd_valid.
- insert_priv_pc=1, priv_pc=0x800 together with npc_sel=1, branch_target=0x400 -> next iaddr=0x800.
- Redirect to 0x402 -> no iren, fd_mal_insn=1, fd_instr=NOP; ierror=1 on a fetch -> fd_fault_insn=1; nRST=0 mid-request -> pc=0x200, fd_valid=0.
